temp_bcd_convert: RTL
=====================

TEMP_BCD_CONVERT -- requirements
Module: temp_bcd_convert

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port: system_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: raw_data  input  16  sensor temperature word; [15:3] = 13-bit two's complement, 0.0625 C/LSB; [2:0] ignored.
REQ-005 SHALL have port: data_valid  input  1  level flag from the sensor reader; its rising edge marks raw_data as new.
REQ-006 SHALL have port: sign  output  1  1 = negative temperature.
REQ-007 SHALL have ports: bcd_hundreds, bcd_tens, bcd_ones  output  4 each  BCD digits of the integer magnitude.
REQ-008 SHALL have port: bcd_tenths  output  4  BCD tenths digit, truncated.
REQ-009 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when the outputs update.

Function
REQ-011 SHALL register data_valid into valid_d (reset 0).
- Start condition: valid_d=0 and data_valid=1 while in IDLE.
REQ-012 SHALL use states IDLE, LOAD, CONV, FRAC, DONE.
REQ-013 In IDLE on a start condition, SHALL capture raw_data[15:3], set busy=1 and go to LOAD.
REQ-014 In LOAD (1 cycle), SHALL compute sign = captured bit 12 and mag = |value| as 13 bits.
- int = mag[12:4] (9 bits, 0..256); frac = mag[3:0].
- Shift counter cleared; next state CONV.
REQ-015 In CONV, SHALL run sequential double-dabble, one shift per cycle, for exactly 9 cycles.
- Each cycle: add 3 to any BCD nibble >= 5, then shift int into the 12-bit BCD register.
- After the 9th shift, go to FRAC.
REQ-016 In FRAC (1 cycle), SHALL compute tenths = (frac*10)>>4 (range 0..9).
REQ-017 In DONE (1 cycle), SHALL update sign and all four BCD outputs together, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-018 Latency SHALL be fixed: done high in the cycle following the 12th rising edge after the capture edge.
REQ-019 Outputs SHALL hold their last values between conversions; no output may change except in DONE.
REQ-020 Rising edges of data_valid while busy=1 SHALL be ignored (no queuing).
- valid_d keeps tracking data_valid, so an edge seen during busy never triggers later.
REQ-021 A data_valid level held high SHALL trigger exactly one conversion.
REQ-022 Value -256.0 C (mag 4096) SHALL convert to 2,5,6 with sign=1.
- raw[2:0] SHALL NOT affect any result.
REQ-023 Negative zero SHALL NOT occur: raw 0 SHALL give sign=0.

Reset
REQ-024 While rst=1, SHALL force state=IDLE, valid_d=0, busy=0, done=0, sign=0, all BCD outputs 0 and internal registers 0.
REQ-025 rst asserted mid-conversion SHALL abort immediately.
- No done pulse; outputs read 0.
- After release, a data_valid that is already high SHALL start a new conversion (valid_d=0).

Verification
REQ-026 Apply raw_data=16'h0C80 with a data_valid rising edge -> done after 12 cycles.
- Expected: sign=0, digits 0,2,5, tenths 0.
REQ-027 Apply raw_data=16'hFAC0 (-10.5 C) -> sign=1, digits 0,1,0, tenths 5.
REQ-028 Apply 16'h4B00 (150.0 C) -> 0,1,5,0,0.
- Apply 16'h8000 -> sign=1, digits 2,5,6, tenths 0.
- Apply 16'h007F -> 0,0,0,0, tenths 9.
REQ-029 Give a second data_valid edge 5 cycles into a conversion -> exactly one done pulse, with the results of the first word only.
REQ-030 Assert rst 6 cycles into a conversion with data_valid held high -> no done, outputs 0.
- After release: one conversion completes 13 cycles later (1 detect plus 12).
REQ-031 Keep data_valid high for 1000 cycles -> exactly one done pulse; busy low otherwise.

Source files
------------

// File: rtl/temp_bcd_convert.sv
// Sequential temperature-to-BCD converter.
// Takes a 13-bit two's complement sensor reading (0.0625 C/LSB) and produces the sign, three
// integer BCD digits and a truncated tenths digit. Conversion latency is fixed at 12 cycles
// after the capture edge. Outputs change only in the DONE state.
module temp_bcd_convert (
  input  logic        system_clk,
  input  logic        rst,
  input  logic [15:0] raw_data,
  input  logic        data_valid,
  output logic        sign,
  output logic [3:0]  bcd_hundreds,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic [3:0]  bcd_tenths,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StConv,
    StFrac,
    StDone
  } state_t;

  state_t      state_q;
  logic        valid_d;
  logic [12:0] word_q;
  logic        sign_q;
  logic [8:0]  int_sr_q;
  logic [11:0] bcd_q;
  logic [3:0]  frac_q;
  logic [3:0]  tenths_q;
  logic [3:0]  cnt_q;

  logic [12:0] mag;
  logic [11:0] bcd_adj;
  logic [7:0]  frac_x10;
  logic        start;

  // Low three bits of the sensor word carry no temperature information.
  logic unused_raw_lsbs;
  assign unused_raw_lsbs = ^raw_data[2:0];

  assign start = !valid_d && data_valid;

  // Magnitude of the captured word; -4096 maps to 13'h1000, which still fits.
  always_comb begin
    mag = word_q;
    if (word_q[12]) begin
      mag = 13'd0 - word_q;
    end
  end

  // Double-dabble correction: add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5)   bcd_adj[3:0]   = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5)   bcd_adj[7:4]   = bcd_q[7:4] + 4'd3;
    if (bcd_q[11:8] >= 4'd5)  bcd_adj[11:8]  = bcd_q[11:8] + 4'd3;
  end

  // frac * 10 as shift-and-add; upper nibble is the truncated tenths digit.
  always_comb begin
    frac_x10 = ({4'd0, frac_q} << 3) + ({4'd0, frac_q} << 1);
  end

  // Edge detector history for data_valid; tracks the input even while busy.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      valid_d <= 1'b0;
    end else begin
      valid_d <= data_valid;
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      word_q       <= '0;
      sign_q       <= 1'b0;
      int_sr_q     <= '0;
      bcd_q        <= '0;
      frac_q       <= '0;
      tenths_q     <= '0;
      cnt_q        <= '0;
      sign         <= 1'b0;
      bcd_hundreds <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      bcd_tenths   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            word_q  <= raw_data[15:3];
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          sign_q   <= word_q[12];
          int_sr_q <= mag[12:4];
          frac_q   <= mag[3:0];
          bcd_q    <= '0;
          cnt_q    <= '0;
          state_q  <= StConv;
        end
        StConv: begin
          bcd_q    <= {bcd_adj[10:0], int_sr_q[8]};
          int_sr_q <= {int_sr_q[7:0], 1'b0};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            state_q <= StFrac;
          end
        end
        StFrac: begin
          tenths_q <= frac_x10[7:4];
          state_q  <= StDone;
        end
        StDone: begin
          sign         <= sign_q;
          bcd_hundreds <= bcd_q[11:8];
          bcd_tens     <= bcd_q[7:4];
          bcd_ones     <= bcd_q[3:0];
          bcd_tenths   <= tenths_q;
          done         <= 1'b1;
          busy         <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
